// File: rtl/shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
// The master drives operands and accepts products; the slave is the multiplier.
interface shift_add_multiplier_if #(parameter int WIDTH = 4);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, product);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, product);
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one ripple add plus one right
// shift per cycle, valid/ready on both the operand and the result side.
module shift_add_multiplier_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m, acc, q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] sum;
  logic             c;
  logic [WIDTH-1:0] add_s, acc_nx, q_nx;

  // Ripple-carry adder: one full-adder cell per bit, cin tied low.
  assign cy[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    shift_add_multiplier_fa u_fa (
      .x (acc[i]),
      .y (m[i]),
      .ci(cy[i]),
      .s (sum[i]),
      .co(cy[i+1])
    );
  end

  // The carry lives only between add and shift; it always shifts into A's MSB.
  assign c      = q[0] & cy[WIDTH];
  assign add_s  = q[0] ? sum : acc;
  assign acc_nx = {c, add_s[WIDTH-1:1]};
  assign q_nx   = {add_s[0], q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.product   <= '0;
      m             <= '0;
      acc           <= '0;
      q             <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          m            <= bus.a;
          q            <= bus.b;
          acc          <= '0;
          cnt          <= CNT_INIT;
          state        <= CALC;
          bus.in_ready <= 1'b0;
        end
        CALC: begin
          acc <= acc_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            bus.product   <= {acc_nx, q_nx};
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomized bench for shift_add_multiplier: a cycle-level protocol model with
// plain a*b arithmetic is checked on every falling edge, plus literal products.
module tb_shift_add_multiplier;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0, bad = 0;
  int   accepted = 0, handshakes = 0, sent_ok = 0;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();
  shift_add_multiplier #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: 0=idle, 1=busy (edges left), 2=result held.
  int             mst = 0, left = 0;
  logic [2*W-1:0] pend = '0, last_prod = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_product", bus.product, 0);
      mst = 0;
      last_prod = '0;
    end else begin
      chk("in_ready", bus.in_ready, 32'(mst == 0));
      chk("out_valid", bus.out_valid, 32'(mst == 2));
      chk("product", bus.product, last_prod);
      case (mst)
        0: if (bus.in_valid) begin
          mst = 1;
          left = W;
          pend = {{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b};
          accepted++;
        end
        1: begin
          left--;
          if (left == 0) begin
            mst = 2;
            last_prod = pend;
          end
        end
        default: if (bus.out_ready) begin
          mst = 0;
          handshakes++;
        end
      endcase
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout got=%0d want=<50", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
  endtask

  task automatic recv(input int stall, output logic [2*W-1:0] p);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL recv_timeout got=%0d want=<50", n);
    end
    p = bus.product;
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_ready", bus.in_ready, 0);
      chk("stall_prod", bus.product, p);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("back_idle", bus.in_ready, 1);
  endtask

  int             perm[256];
  logic [2*W-1:0] p;

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-scale operands, latency checked by the model
    send(4'hF, 4'hF); sent_ok++;
    recv(0, p); chk("ff_x_ff", p, 8'hE1);

    send(4'd13, 4'd11); sent_ok++;
    recv(0, p); chk("13x11", p, 8'h8F);
    send(4'd0, 4'd9); sent_ok++;
    recv(1, p); chk("0x9", p, 8'h00);
    send(4'd1, 4'd7); sent_ok++;
    recv(0, p); chk("1x7", p, 8'h07);

    // Long consumer stall
    send(4'd6, 4'd7); sent_ok++;
    recv(5, p); chk("6x7_stall", p, 8'h2A);

    // New operands offered mid-calculation must be dropped
    send(4'd2, 4'd3); sent_ok++;
    bus.in_valid = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
    repeat (2) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    recv(0, p); chk("2x3_ignore", p, 8'h06);
    repeat (8) begin
      @(posedge clk); #1;
      chk("no_extra_result", bus.out_valid, 0);
    end

    // Abort mid-calculation
    send(4'd7, 4'd7);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_product", bus.product, 0);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_ready", bus.in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    send(4'd3, 4'd5); sent_ok++;
    recv(0, p); chk("3x5_after_rst", p, 8'h0F);

    // All 256 pairs in shuffled order with random gaps and stalls
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      logic [W-1:0] x, y;
      x = W'(perm[i] >> W);
      y = W'(perm[i]);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(x, y); sent_ok++;
      recv($urandom_range(0, 3), p);
      chk("sweep", p, {{W{1'b0}}, x} * {{W{1'b0}}, y});
    end

    repeat (4) @(posedge clk);
    chk("handshakes", handshakes, sent_ok);
    chk("accepted", accepted, sent_ok + 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0t want=<500000", $time);
    $fatal(1, "bench did not complete");
  end
endmodule
